// File: rtl/pes_seq_mult_if.sv
// Handshake bundle between a controller (master) and the pes_seq_mult shift-add multiplier (slave).
interface pes_seq_mult_if #(
   parameter int WIDTH = 4
);
   logic                 start;
   logic                 signed_mode;
   logic [WIDTH-1:0]     A;
   logic [WIDTH-1:0]     B;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;

   modport master (
      output start, signed_mode, A, B,
      input  busy, done, product
   );

   modport slave (
      input  start, signed_mode, A, B,
      output busy, done, product
   );
endinterface

// File: rtl/pes_seq_mult.sv
// Sequential shift-add multiplier: one partial product per clock, signed via magnitude + sign fix-up.
// Optional macro EARLY_TERM_EN finishes as soon as the remaining multiplier bits are all zero.
module pes_seq_mult #(
   parameter int WIDTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   pes_seq_mult_if.slave   bus
);
   localparam int PW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t            state_q, state_d;
   logic [PW-1:0]     mcand_q, mcand_d;
   logic [PW-1:0]     acc_q, acc_d;
   logic [PW-1:0]     product_q, product_d;
   logic [WIDTH-1:0]  mplier_q, mplier_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              neg_q, neg_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic [WIDTH-1:0]  mag_a, mag_b;
   logic              last_step;

   // The most negative operand negates to itself, which read as unsigned is exactly its magnitude.
   assign mag_a = (bus.signed_mode && bus.A[WIDTH-1]) ? (~bus.A + 1'b1) : bus.A;
   assign mag_b = (bus.signed_mode && bus.B[WIDTH-1]) ? (~bus.B + 1'b1) : bus.B;

   always_comb begin
      // NOTE: every _d starts from its _q (or a safe constant) so no branch can infer a latch.
      state_d   = state_q;
      mcand_d   = mcand_q;
      acc_d     = acc_q;
      product_d = product_q;
      mplier_d  = mplier_q;
      cnt_d     = cnt_q;
      neg_d     = neg_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      last_step = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               mcand_d  = PW'(mag_a);
               mplier_d = mag_b;
               acc_d    = '0;
               cnt_d    = '0;
               neg_d    = bus.signed_mode & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
               busy_d   = 1'b1;
               state_d  = CALC;
            end
         end

         CALC: begin
            if (mplier_q[0]) begin
               acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
`ifdef EARLY_TERM_EN
            last_step = (cnt_q == LAST_CNT) || (mplier_d == '0);
`else
            last_step = (cnt_q == LAST_CNT);
`endif
            if (last_step) begin
               busy_d  = 1'b0;
               state_d = DONE;
            end
         end

         DONE: begin
            product_d = neg_q ? (~acc_q + 1'b1) : acc_q;
            done_d    = 1'b1;
            state_d   = IDLE;
         end

         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: datapath registers are reset as well, so an aborted operation leaves no residue.
         state_q   <= IDLE;
         mcand_q   <= '0;
         acc_q     <= '0;
         product_q <= '0;
         mplier_q  <= '0;
         cnt_q     <= '0;
         neg_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the pre-edge values together.
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         acc_q     <= acc_d;
         product_q <= product_d;
         mplier_q  <= mplier_d;
         cnt_q     <= cnt_d;
         neg_q     <= neg_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.product = product_q;
endmodule

// File: tb/tb_pes_seq_mult.sv
// Randomised self-checking bench for pes_seq_mult against an arithmetic reference model.
module tb_pes_seq_mult;
   localparam int W      = 4;
   localparam int PW     = 2 * W;
   localparam int BUDGET = 4 * W + 10;

   typedef logic [PW-1:0] prod_t;
   typedef logic [W-1:0]  opnd_t;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   pes_seq_mult_if #(.WIDTH(W)) bus ();

   pes_seq_mult #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic longint to_int(input opnd_t v, input bit sm);
      longint x;
      x = longint'(v);
      if (sm && x >= (longint'(1) << (W - 1))) x = x - (longint'(1) << W);
      return x;
   endfunction

   function automatic prod_t model_prod(input opnd_t a, input opnd_t b, input bit sm);
      longint p;
      p = to_int(a, sm) * to_int(b, sm);
      return prod_t'(p);
   endfunction

   // Edges from accept to the edge after which done is visible.
   function automatic int model_lat(input opnd_t b, input bit sm);
`ifdef EARLY_TERM_EN
      longint mag;
      int     hi;
      mag = to_int(b, sm);
      if (mag < 0) mag = -mag;
      hi = 0;
      while (mag > 1) begin
         mag = mag / 2;
         hi++;
      end
      return hi + 2;
`else
      return W + 1;
`endif
   endfunction

   task automatic run_op(input opnd_t a, input opnd_t b, input bit sm, input bit reinject);
      prod_t exp_p;
      prod_t prev;
      int    exp_l;
      int    cyc;
      int    busy_cnt;
      bit    moved;
      exp_p = model_prod(a, b, sm);
      exp_l = model_lat(b, sm);
      prev  = bus.product;
      bus.A           = a;
      bus.B           = b;
      bus.signed_mode = sm;
      bus.start       = 1'b1;
      @(posedge clk);
      #1;
      bus.start       = 1'b0;
      bus.A           = W'($urandom);
      bus.B           = W'($urandom);
      bus.signed_mode = 1'($urandom);
      cyc      = 0;
      busy_cnt = 0;
      moved    = 1'b0;
      while (cyc <= BUDGET) begin
         if (cyc == 2) bus.start = 1'b0;
         if (bus.done) break;
         if (bus.busy) busy_cnt++;
         if (bus.product !== prev) moved = 1'b1;
         if (reinject && cyc == 1) begin
            bus.start       = 1'b1;
            bus.A           = ~a;
            bus.B           = ~b;
            bus.signed_mode = ~sm;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      if (cyc > BUDGET) begin
         check("done_timeout", cyc, exp_l);
      end else begin
         check("latency", cyc, exp_l);
         check("product", bus.product, exp_p);
         check("busy_cycles", busy_cnt, exp_l - 1);
         check("product_stable", moved, 0);
      end
   endtask

   typedef struct {
      opnd_t a;
      opnd_t b;
      bit    sm;
   } vec_t;

   vec_t directed[$];
   bit   seen_done;

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst             = 1'b1;
      bus.start       = 1'b0;
      bus.signed_mode = 1'b0;
      bus.A           = '0;
      bus.B           = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_product", bus.product, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      directed = '{
         '{4'h8, 4'h8, 1'b0}, '{4'h1, 4'h1, 1'b0}, '{4'h2, 4'h2, 1'b0},
         '{4'h0, 4'h0, 1'b0}, '{4'hF, 4'hF, 1'b0}, '{4'h8, 4'h8, 1'b1},
         '{4'h8, 4'h7, 1'b1}, '{4'hF, 4'h1, 1'b1}, '{4'h9, 4'h1, 1'b0},
         '{4'h9, 4'h8, 1'b0}, '{4'h5, 4'h0, 1'b1}, '{4'h3, 4'hC, 1'b1}
      };
      foreach (directed[i]) run_op(directed[i].a, directed[i].b, directed[i].sm, 1'b0);

      // Restart during CALC is ignored; a start right after done is accepted.
      run_op(4'h6, 4'h7, 1'b0, 1'b1);
      run_op(4'h3, 4'h4, 1'b0, 1'b0);

      // Abort mid-operation with an asynchronous reset.
      run_op(4'h7, 4'h9, 1'b0, 1'b0);
      bus.A     = 4'h5;
      bus.B     = 4'h6;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("abort_busy", bus.busy, 0);
      check("abort_done", bus.done, 0);
      check("abort_product", bus.product, 0);
      #2;
      rst = 1'b0;
      seen_done = 1'b0;
      repeat (2 * W + 4) begin
         @(posedge clk);
         #1;
         if (bus.done) seen_done = 1'b1;
      end
      check("abort_no_done", seen_done, 0);
      run_op(4'h3, 4'h5, 1'b0, 1'b0);

      repeat (60) begin
         repeat ($urandom_range(2)) begin
            @(posedge clk);
            #1;
         end
         run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom_range(3) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/pes_seq_mult.md
Name: pes_seq_mult

Overview:
Parametrised sequential shift-add multiplier; successor to the fixed 4x4 combinational pes_se_M.
- Operand width is generic; per-operation unsigned/signed mode selected at the port.
- start/busy/done handshake; one partial product per clock, so it scales to wide operands without a large combinational array.
- Result is held until the next completion. Sits as a shared arithmetic unit behind a simple controller.

Parameters:
WIDTH, 4, operand width in bits (>= 2); product is 2*WIDTH bits.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
start  input  1  request; sampled only in IDLE
signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start
A  input  WIDTH  multiplicand; sampled with start
B  input  WIDTH  multiplier; sampled with start
busy  output  1  high while in CALC
done  output  1  one-cycle pulse when product is updated
product  output  2*WIDTH  last completed result

Behaviour:
Clock, reset and reset values:
- One clock (clk). Reset is asynchronous and active-high (rst).
- rst forces state=IDLE, busy=0, done=0, product=0, and clears all internal registers.
- Reset mid-operation aborts the operation; no done is produced. After rst deasserts, the next accepted start behaves normally.

States:
- IDLE: start=1 at an edge latches A, B and signed_mode, then moves to CALC.
- CALC: busy=1. One multiplier bit is processed per cycle: if the bit is 1, the multiplicand is added into a 2*WIDTH accumulator; the multiplicand shifts left and the multiplier shifts right. After WIDTH CALC cycles, moves to DONE.
- DONE: product <= accumulator, sign-corrected; done=1 for this cycle only; then returns to IDLE.

Latency:
- start accepted at edge k; CALC occupies edges k+1..k+WIDTH; done is high and product valid after edge k+WIDTH+1.
- Earliest next accept is at edge k+WIDTH+2.
- start is ignored in CALC and DONE; no queuing.

Signed mode:
- Operands are converted to magnitudes at load, and the result sign is recorded as A[MSB] XOR B[MSB].
- The unsigned magnitude product is negated in DONE if the recorded sign is 1.
- The most negative operand -2^(WIDTH-1) has magnitude 2^(WIDTH-1), which fits in WIDTH unsigned bits. Its square 2^(2*WIDTH-2) fits in the 2*WIDTH signed product; no overflow is possible.

Product and operand handling:
- Unsigned mode: operands are zero-extended; the result is exact in 2*WIDTH bits.
- product changes only at DONE; it is stable at all other times, including through CALC.
- A, B and signed_mode may change freely after acceptance without affecting the operation.

Optional Feature:
Macro EARLY_TERM_EN.
- Defined: in CALC, if the remaining shifted multiplier is zero, go to DONE on the next edge instead of finishing all WIDTH cycles. Latency is (index of highest set bit of |B|) + 2 edges after accept; B=0 gives done at k+2.
- Not defined: CALC always lasts exactly WIDTH cycles; latency is fixed at WIDTH+1.
- Results are identical in both builds.

Test Plan:
- WIDTH=4, unsigned: A=8, B=8, start pulse -> done one cycle at k+5; product=8'h40. Then A=1, B=1 -> 8'h01; A=2, B=2 -> 8'h04; A=0, B=0 -> 8'h00.
- Unsigned max: A=4'hF, B=4'hF -> product=8'hE1 (225); busy high for exactly 4 cycles.
- Signed: A=4'b1000, B=4'b1000 -> 8'h40; A=4'b1000, B=4'b0111 -> 8'hC8 (-56); A=4'hF, B=4'h1 -> 8'hFF (-1).
- start re-asserted during CALC with different operands -> ignored; first result unchanged. A new start at k+6 is accepted.
- rst pulsed at k+2 mid-CALC -> busy=0, done=0, product=0 immediately; no done afterwards. The next operation 3*5 gives 8'h0F.
- EARLY_TERM_EN defined: B=1, A=9 -> done at k+2, product=8'h09. B=4'h8 -> done at k+5. Same vectors without the macro -> done at k+5.
